bus_target_regs: RTL and testbench
==================================

Name: bus_target_regs

Overview:
- Memory-mapped responder on the CPU's native bus: request strobe, write enable, address, write data out; read data and data-ready back.
- Decodes a base-address window and services reads and writes to a bank of DATA_W-bit registers, with programmable wait states.
- Uses a four-phase request/ready handshake.
- First peripheral-side endpoint of this bus; it is the template for later devices.

Parameters:
- DATA_W, 32, width of address and data buses (matches CPU `VW).
- BASE_ADDR, 32'h0000_F000, window base; must be aligned to NUM_REGS*4.
- NUM_REGS, 16, register count, power of two, 2..64.
- WAIT_STATES, 2, extra cycles between request capture and ready, 0..15.
- ID_VALUE, 32'h6583_2001, read-only contents of register 0.
- MISS_DATA, 32'hDEAD_BEEF, read data returned for unmapped or misaligned access.

Ports:
- i_cpu_clk  in  1  block clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bus_clk  in  1  request strobe from CPU (CPU o_bus_clk); level, held until ready seen.
- i_bus_we  in  1  1=write, 0=read; stable while i_bus_clk high.
- i_bus_addr  in  DATA_W  byte address; stable while i_bus_clk high.
- i_bus_data  in  DATA_W  write data from CPU.
- o_bus_data  out  DATA_W  read data to CPU; valid while o_bus_data_ready=1.
- o_bus_data_ready  out  1  response valid / write accepted.
- o_bus_err  out  1  access missed the window (feature-gated, see below).
- o_hit  out  1  registered; 1 while the captured request decodes inside the window.

Behaviour:
- Reset (i_rst_n low, async): FSM=IDLE, all registers 1..NUM_REGS-1 = 0, o_bus_data=0, o_bus_data_ready=0, o_bus_err=0, o_hit=0, wait counter=0. Reset mid-transaction discards it; no write occurs.
- Decode: hit = addr[DATA_W-1:log2(NUM_REGS)+2]==BASE_ADDR upper bits AND addr[1:0]==0. Index = addr[log2(NUM_REGS)+1:2].
- FSM IDLE: on i_bus_clk sampled 1, latch addr/we/data and hit into capture regs; o_hit<=hit; counter<=WAIT_STATES; go WAIT (or RESP directly if WAIT_STATES=0).
- FSM WAIT: counter decrements each cycle. At 0, go RESP. If i_bus_clk sampled 0 (abort), go IDLE: no write, ready never asserted, o_hit<=0.
- FSM RESP (one cycle): assert o_bus_data_ready<=1.
  - Write hit: reg[index]<=captured data. Writes to index 0 are ignored. Write data in the capture reg is used, not the live bus.
  - Read hit: o_bus_data<=reg[index].
  - Miss: o_bus_data<=MISS_DATA, write ignored.
  - Then go HOLD.
- FSM HOLD: keep ready and data stable while i_bus_clk=1. On i_bus_clk sampled 0: ready<=0, o_bus_err<=0, o_hit<=0, go IDLE.
- A new request is only recognised from IDLE, so back-to-back requests need i_bus_clk low for at least 1 cycle.
- Latency: request sampled at edge N → ready high after edge N+1+WAIT_STATES.
- Write data visible to a following read with no hazard; the register update and ready occur on the same edge.
- Register 0 always reads ID_VALUE.

Optional Feature:
- Macro: BUS_TARGET_ERR_EN.
- Defined:
  - On a miss, o_bus_err is asserted together with o_bus_data_ready and held in HOLD.
  - Register 1 becomes a read-only miss counter: increments once per completed missed access (not on aborts), saturating at all-ones.
  - Writes to index 1 are ignored.
- Undefined:
  - o_bus_err is tied 0.
  - Register 1 is an ordinary read/write register.
  - No counter logic is synthesised.

Test Plan:
- Reset then read 0x0000F000 with WAIT_STATES=2 → ready rises after edge N+3, o_bus_data=32'h6583_2001, o_hit=1; ready drops the cycle after i_bus_clk falls.
- Write 32'hCAFE_0042 to 0x0000F008, then read 0x0000F008 → read returns 32'hCAFE_0042; a write to 0x0000F000 leaves the read at ID_VALUE.
- Read 0x00001234 and read 0x0000F002 (misaligned) → o_bus_data=32'hDEAD_BEEF, o_hit=0. With BUS_TARGET_ERR_EN: o_bus_err=1, then a read of 0x0000F004 returns 2.
- Write 0x1111_1111 to 0x0000F00C, dropping i_bus_clk after 1 cycle (abort in WAIT) → ready never asserts; a later read of 0x0000F00C returns 0.
- Assert i_rst_n=0 asynchronously during HOLD → ready and data go to 0 immediately (no clock edge); registers return to 0.
- Run with WAIT_STATES=0 and back-to-back write then read, i_bus_clk low 1 cycle between → each ready arrives after edge N+1; both complete correctly.

Source files
------------

// File: rtl/bus_target_regs.sv
// bus_target_regs: memory-mapped register bank on the CPU native bus with programmable wait states.
// Define BUS_TARGET_ERR_EN for o_bus_err on misses and a read-only saturating miss counter in register 1.
module bus_target_regs #(
    parameter int                WAIT_STATES = 2,
    parameter int                NUM_REGS    = 16,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR   = 32'h0000_F000,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'h6583_2001,
    parameter logic [DATA_W-1:0] MISS_DATA   = 32'hDEAD_BEEF
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst_n,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [DATA_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_data_ready,
    output logic              o_bus_err,
    output logic              o_hit
);
    localparam int IW = $clog2(NUM_REGS);
    localparam logic [DATA_W-1:0] ONE = 1;
`ifdef BUS_TARGET_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d, hit_q, hit_d, rdy_q, rdy_d, err_q, err_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                hit, wr_en, miss_inc;
    logic [DATA_W-1:0]   rd_val;

    assign hit = (i_bus_addr[DATA_W-1:IW+2] == BASE_ADDR[DATA_W-1:IW+2]) && (i_bus_addr[1:0] == 2'b00);
    assign rd_val = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
    // Index 0 is the ID; index 1 becomes the miss counter when the error feature is built in.
    assign wr_en = (state_q == S_RESP) && hit_q && we_q && (idx_q != '0) && !(ERR_EN && idx_q == IW'(1));
    assign miss_inc = ERR_EN && (state_q == S_RESP) && !hit_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (i_bus_clk) begin
                we_d    = i_bus_we;
                hit_d   = hit;
                idx_d   = i_bus_addr[IW+1:2];
                wdata_d = i_bus_data;
                cnt_d   = 4'(WAIT_STATES);
                state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!i_bus_clk) begin
                    hit_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                rdy_d   = 1'b1;
                err_d   = ERR_EN && !hit_q;
                rdata_d = !hit_q ? MISS_DATA : (!we_q ? rd_val : rdata_q);
                state_d = S_HOLD;
            end
            S_HOLD: if (!i_bus_clk) begin
                rdy_d   = 1'b0;
                err_d   = 1'b0;
                hit_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) regs_q <= '{default: '0};
        else begin
            if (wr_en) regs_q[idx_q] <= wdata_q;
            if (miss_inc && !(&regs_q[1])) regs_q[1] <= regs_q[1] + ONE;
        end
    end

    assign o_bus_data       = rdata_q;
    assign o_bus_data_ready = rdy_q;
    assign o_bus_err        = err_q;
    assign o_hit            = hit_q;
endmodule

// File: tb/tb_bus_target_regs.sv
// tb_bus_target_regs: scoreboard bench for bus_target_regs (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_bus_target_regs;
    localparam logic [31:0] ID   = 32'h6583_2001;
    localparam logic [31:0] MISS = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic        chk;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        rdy [2];
    logic        err [2];
    logic        hit [2];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    bus_target_regs #(.WAIT_STATES(0)) dut0 (
        .i_cpu_clk(clk), .i_rst_n(rst_n), .i_bus_clk(req[0]), .i_bus_we(we[0]),
        .i_bus_addr(addr[0]), .i_bus_data(wdata[0]), .o_bus_data(rdata[0]),
        .o_bus_data_ready(rdy[0]), .o_bus_err(err[0]), .o_hit(hit[0])
    );

    bus_target_regs #(.WAIT_STATES(2)) dut2 (
        .i_cpu_clk(clk), .i_rst_n(rst_n), .i_bus_clk(req[1]), .i_bus_we(we[1]),
        .i_bus_addr(addr[1]), .i_bus_data(wdata[1]), .o_bus_data(rdata[1]),
        .o_bus_data_ready(rdy[1]), .o_bus_err(err[1]), .o_hit(hit[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // d selects the instance: 0 -> no wait states, 1 -> two wait states.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic eh, input logic chk);
        exp_t e;
        int   n;
        e.data = ed;
        e.hit  = eh;
        e.chk  = chk;
        e.lat  = (d == 0) ? 2 : 4;
        sb.push_back(e);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy[d] && n < 20);
        e = sb.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        if (e.chk) check("rdata", rdata[d], e.data);
        check("hit", {31'b0, hit[d]}, {31'b0, e.hit});
        check("err", {31'b0, err[d]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 check("hold_rdy", {31'b0, rdy[d]}, 32'd1);
        @(negedge clk) req[d] = 1'b0;
        @(posedge clk); #1;
        check("drop_rdy", {31'b0, rdy[d]}, 32'd0);
        check("drop_hit", {31'b0, hit[d]}, 32'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", {31'b0, rdy[1]}, 32'd0);
        check("rst_data", rdata[1], 32'd0);
        check("rst_hit", {31'b0, hit[1]}, 32'd0);
        check("rst_err", {31'b0, err[1]}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        xfer(1, 1'b0, 32'h0000_F000, 32'h0, ID, 1'b1, 1'b1);
        xfer(1, 1'b1, 32'h0000_F008, 32'hCAFE_0042, 32'h0, 1'b1, 1'b0);
        xfer(1, 1'b0, 32'h0000_F008, 32'h0, 32'hCAFE_0042, 1'b1, 1'b1);
        xfer(1, 1'b1, 32'h0000_F000, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        xfer(1, 1'b0, 32'h0000_F000, 32'h0, ID, 1'b1, 1'b1);
        xfer(1, 1'b0, 32'h0000_1234, 32'h0, MISS, 1'b0, 1'b1);
        xfer(1, 1'b0, 32'h0000_F002, 32'h0, MISS, 1'b0, 1'b1);
        xfer(1, 1'b0, 32'h0000_F004, 32'h0, 32'h0, 1'b1, 1'b1);
        xfer(1, 1'b1, 32'h0000_F004, 32'h5A5A_0001, 32'h0, 1'b1, 1'b0);
        xfer(1, 1'b0, 32'h0000_F004, 32'h0, 32'h5A5A_0001, 1'b1, 1'b1);
        xfer(1, 1'b1, 32'h0000_F03C, 32'hA5A5_003C, 32'h0, 1'b1, 1'b0);
        xfer(1, 1'b0, 32'h0000_F03C, 32'h0, 32'hA5A5_003C, 1'b1, 1'b1);
        xfer(1, 1'b1, 32'h0000_F040, 32'h7777_7777, MISS, 1'b0, 1'b1);
        xfer(1, 1'b0, 32'h0000_F008, 32'h0, 32'hCAFE_0042, 1'b1, 1'b1);

        // Abort while waiting: strobe drops one cycle after capture.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_F00C; wdata[1] = 32'h1111_1111;
        @(negedge clk) req[1] = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy[1]) seen = 1;
        end
        check("abort_rdy", 32'(seen), 32'd0);
        check("abort_hit", {31'b0, hit[1]}, 32'd0);
        xfer(1, 1'b0, 32'h0000_F00C, 32'h0, 32'h0, 1'b1, 1'b1);

        xfer(0, 1'b1, 32'h0000_F010, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b0);
        xfer(0, 1'b0, 32'h0000_F010, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b1);
        xfer(0, 1'b0, 32'h0000_F000, 32'h0, ID, 1'b1, 1'b1);

        // Asynchronous reset while holding a read response.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0000_F008;
        repeat (5) @(posedge clk);
        #1 check("pre_rst_rdy", {31'b0, rdy[1]}, 32'd1);
        check("pre_rst_data", rdata[1], 32'hCAFE_0042);
        #2 rst_n = 1'b0;
        #1;
        check("async_rdy", {31'b0, rdy[1]}, 32'd0);
        check("async_data", rdata[1], 32'd0);
        check("async_hit", {31'b0, hit[1]}, 32'd0);
        req[1] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        xfer(1, 1'b0, 32'h0000_F008, 32'h0, 32'h0, 1'b1, 1'b1);
        xfer(1, 1'b0, 32'h0000_F004, 32'h0, 32'h0, 1'b1, 1'b1);
        xfer(0, 1'b0, 32'h0000_F010, 32'h0, 32'h0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
